// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular-arithmetic datapath blocks.
//   state_e    : sequencer states of the iterative multiplier
//   cnt_width  : width of a bit-index counter able to address dw bits
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int dw);
        return $clog2(dw);
    endfunction

endpackage

// File: rtl/mod_reduce_add.sv
// One modular add step: r = (x + y) reduced once against m.
// The sum is formed at DATA_WIDTH+1 bits so the carry is kept. It is
// truncated only after the conditional subtract. Exact when x, y < m.
//   x, y : addends (DATA_WIDTH)
//   m    : modulus (DATA_WIDTH)
//   r    : reduced sum (DATA_WIDTH)
module mod_reduce_add #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic [DATA_WIDTH-1:0] m,
    output logic [DATA_WIDTH-1:0] r
);

    logic [DATA_WIDTH:0] sum;

    assign sum = {1'b0, x} + {1'b0, y};
    assign r   = (sum >= {1'b0, m}) ? DATA_WIDTH'(sum - {1'b0, m})
                                    : sum[DATA_WIDTH-1:0];

endmodule

// File: rtl/mod_mult_iter.sv
// Iterative modular multiplier: out = (a * b) mod modulant.
// Interleaved double-and-add, one bit of b per cycle, MSB first.
// Result appears DATA_WIDTH cycles after accept. For a modulus below 2
// the result is 0 and appears in the cycle after accept.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, modulant)
//   out_valid / out_ready: result handshake (out)
module mod_mult_iter
    import mod_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int CNT_WIDTH = cnt_width(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, out_q, out_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dbl, dbl_add, acc_step;

    // Doubling stage, then add-multiplicand stage. Both use the same reducer.
    mod_reduce_add #(.DATA_WIDTH(DATA_WIDTH)) u_dbl (
        .x (acc_q), .y (acc_q), .m (m_q), .r (dbl)
    );
    mod_reduce_add #(.DATA_WIDTH(DATA_WIDTH)) u_add (
        .x (dbl), .y (a_q), .m (m_q), .r (dbl_add)
    );

    assign acc_step = b_q[cnt_q] ? dbl_add : dbl;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    m_d   = modulant;
                    acc_d = '0;
                    cnt_d = CNT_WIDTH'(DATA_WIDTH - 1);
                    if (modulant < DATA_WIDTH'(2)) begin
                        // mod 0 and mod 1 are defined as 0. Skip iterating.
                        state_d = DONE;
                        out_d   = '0;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    out_d   = acc_step;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // The result register holds the last result through IDLE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;

endmodule

// File: tb/tb_mod_mult_iter.sv
module tb_mod_mult_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic       iv8 = 0, ir8, ov8, or8 = 1;
    logic [7:0] a8 = 0, b8 = 0, m8 = 0, o8;
    mod_mult_iter #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .modulant(m8), .out_valid(ov8), .out_ready(or8), .out(o8)
    );

    // 16-bit instance
    logic        iv16 = 0, ir16, ov16, or16 = 1;
    logic [15:0] a16 = 0, b16 = 0, m16 = 0, o16;
    mod_mult_iter #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .modulant(m16), .out_valid(ov16), .out_ready(or16), .out(o16)
    );

    int n_chk = 0;
    int n_fail = 0;
    int acc_cyc = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain modular product; a modulus below 2 gives 0.
    function automatic longint ref_mod(input longint x, input longint y, input longint m);
        return (m < 2) ? 0 : (x * y) % m;
    endfunction

    // Present operands at a negedge and take them on the next posedge. Then
    // scramble the inputs, which must have no effect on the result.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        a8 = a; b8 = b; m8 = m; iv8 = 1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        iv8 = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom);
    endtask

    // Count edges after accept until out_valid. in_ready must stay low.
    task automatic wait8(input logic [7:0] exp, input int exp_lat, input string nm);
        int  lat;
        bit  busy_ok;
        lat = 0;
        busy_ok = 1;
        while (!ov8 && lat < 40) begin
            if (ir8) busy_ok = 0;
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " out"}, o8, exp);
        check({nm, " in_ready low while busy/done"}, {busy_ok, ir8}, 2'b10);
    endtask

    // Complete the result handshake and check the return to idle.
    task automatic handshake8(input logic [7:0] exp, input string nm);
        or8 = 1;
        @(negedge clk);
        check({nm, " idle ready/valid"}, {ir8, ov8}, 2'b10);
        check({nm, " out held in idle"}, o8, exp);
    endtask

    typedef struct {
        logic [7:0] a, b, m, exp;
        int         lat;
        string      nm;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   prev_acc;
        vecs[0] = '{a: 8'd200, b: 8'd150, m: 8'd251, exp: 8'd131, lat: 8, nm: "v200x150m251"};
        vecs[1] = '{a: 8'd254, b: 8'd254, m: 8'd255, exp: 8'd1,   lat: 8, nm: "v254x254m255"};
        vecs[2] = '{a: 8'd0,   b: 8'd77,  m: 8'd101, exp: 8'd0,   lat: 8, nm: "v0x77m101"};
        vecs[3] = '{a: 8'd100, b: 8'd1,   m: 8'd101, exp: 8'd100, lat: 8, nm: "v100x1m101"};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   m: 8'd1,   exp: 8'd0,   lat: 0, nm: "vm1"};
        vecs[5] = '{a: 8'd0,   b: 8'd0,   m: 8'd0,   exp: 8'd0,   lat: 0, nm: "vm0"};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset ready/valid", {ir8, ov8}, 2'b10);
        check("reset out", o8, 0);
        rst_n = 1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            start8(vecs[i].a, vecs[i].b, vecs[i].m);
            wait8(vecs[i].exp, vecs[i].lat, vecs[i].nm);
            handshake8(vecs[i].exp, vecs[i].nm);
        end

        // Backpressure: result must hold while out_ready is low, new operands ignored
        or8 = 0;
        start8(8'd200, 8'd150, 8'd251);
        wait8(8'd131, 8, "bp");
        for (int k = 0; k < 5; k++) begin
            iv8 = 1; a8 = 8'd3; b8 = 8'd5; m8 = 8'd7;
            @(negedge clk);
            check("bp hold valid/ready", {ov8, ir8}, 2'b10);
            check("bp hold out", o8, 131);
        end
        iv8 = 0;
        handshake8(8'd131, "bp");

        // Back-to-back issue interval of DATA_WIDTH+2
        prev_acc = -1;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] m, x, y;
            m = 8'($urandom_range(255, 2));
            x = 8'($urandom % m);
            y = 8'($urandom % m);
            start8(x, y, m);
            if (prev_acc >= 0) check("b2b interval", acc_cyc - prev_acc, 10);
            prev_acc = acc_cyc;
            wait8(8'(ref_mod(x, y, m)), 8, "b2b");
            handshake8(8'(ref_mod(x, y, m)), "b2b");
        end

        // Async reset mid-busy. The previous result is nonzero, so out must clear.
        start8(8'd100, 8'd1, 8'd101);
        wait8(8'd100, 8, "pre-rst");
        handshake8(8'd100, "pre-rst");
        start8(8'd200, 8'd150, 8'd251);
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async rst valid/ready", {ov8, ir8}, 2'b01);
        check("async rst out", o8, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start8(8'd3, 8'd5, 8'd7);
        wait8(8'd1, 8, "post-rst");
        handshake8(8'd1, "post-rst");

        // Random 8-bit ops against the reference
        for (int k = 0; k < 30; k++) begin
            logic [7:0] m, x, y;
            m = 8'($urandom_range(255, 2));
            x = 8'($urandom % m);
            y = 8'($urandom % m);
            start8(x, y, m);
            wait8(8'(ref_mod(x, y, m)), 8, $sformatf("rnd8 %0d*%0d%%%0d", x, y, m));
            handshake8(8'(ref_mod(x, y, m)), "rnd8");
        end

        // Random 16-bit ops with operand scrambling during busy
        for (int k = 0; k < 20; k++) begin
            logic [15:0] m, x, y;
            int lat;
            m = 16'($urandom_range(65535, 2));
            x = 16'($urandom % m);
            y = 16'($urandom % m);
            a16 = x; b16 = y; m16 = m; iv16 = 1;
            @(posedge clk);
            @(negedge clk);
            iv16 = 0;
            a16 = 16'($urandom); b16 = 16'($urandom); m16 = 16'($urandom);
            lat = 0;
            while (!ov16 && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("rnd16 latency %0d", k), lat, 16);
            check($sformatf("rnd16 %0d*%0d%%%0d", x, y, m), o16, ref_mod(x, y, m));
            @(negedge clk);
            check("rnd16 idle ready", ir16, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
